// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack handshake and presents
// the registered word to decode, applying jump/branch/sequential next-PC on consume.
//
//   state | meaning
//   FETCH | request outstanding at pc, waiting for imem_ack_i
//   HAVE  | instruction registered and valid, waiting for decode to consume
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o32,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i32,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [15:0] branch_off_i16,
    input  logic        pc_j_i,
    input  logic [25:0] jaddr_i26,
    output logic        instr_valid_o,
    output logic [31:0] instr_o32,
    output logic [5:0]  op_o6,
    output logic [31:0] pc_o32,
    output logic [31:0] pc_plus4_o32,
    output logic        bus_err_o,
    output logic        align_err_o
);
    localparam int            CW  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(ACK_TIMEOUT);

    typedef enum logic {FETCH, HAVE} state_t;

    state_t        state, state_nxt;
    logic [31:0]   pc, pc_nxt, pc_plus4, target, instr;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          bus_err, bus_err_nxt, align_err, align_err_nxt, load_instr;

    // Jump beats branch; the target is formed unmasked so misalignment stays observable.
    always_comb begin
        pc_plus4 = pc + 32'd4;
        if (pc_j_i)
            target = {pc_plus4[31:28], jaddr_i26, 2'b00};
        else if (branch_i)
            target = pc_plus4 + {{14{branch_off_i16[15]}}, branch_off_i16, 2'b00};
        else
            target = pc_plus4;
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        cnt_nxt       = cnt;
        bus_err_nxt   = bus_err;
        align_err_nxt = align_err;
        load_instr    = 1'b0;
        case (state)
            FETCH: begin
                if (imem_ack_i) begin
                    load_instr = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = HAVE;
                end else begin
                    if (cnt < TMO)
                        cnt_nxt = cnt + CW'(1);
                    if (cnt_nxt == TMO)
                        bus_err_nxt = 1'b1;
                end
            end
            HAVE: begin
                if (!stall_i) begin
                    pc_nxt    = {target[31:2], 2'b00};
                    state_nxt = FETCH;
                    if (target[1:0] != 2'b00)
                        align_err_nxt = 1'b1;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= FETCH;
            pc        <= {RESET_PC[31:2], 2'b00};
            instr     <= '0;
            cnt       <= '0;
            bus_err   <= 1'b0;
            align_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            cnt       <= cnt_nxt;
            bus_err   <= bus_err_nxt;
            align_err <= align_err_nxt;
            if (load_instr)
                instr <= imem_rdata_i32;
        end
    end

    assign imem_req_o    = (state == FETCH);
    assign instr_valid_o = (state == HAVE);
    assign imem_addr_o32 = pc;
    assign pc_o32        = pc;
    assign pc_plus4_o32  = pc_plus4;
    assign instr_o32     = instr;
    assign op_o6         = instr[31:26];
    assign bus_err_o     = bus_err;
    assign align_err_o   = align_err;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized instruction stream checked
// against an arithmetic PC/handshake model.
module tb_fetch_unit;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o32;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i32 = '0;
    logic        stall_i = 1'b1;
    logic        branch_i = 1'b0;
    logic [15:0] branch_off_i16 = '0;
    logic        pc_j_i = 1'b0;
    logic [25:0] jaddr_i26 = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o32;
    logic [5:0]  op_o6;
    logic [31:0] pc_o32;
    logic [31:0] pc_plus4_o32;
    logic        bus_err_o;
    logic        align_err_o;

    fetch_unit #(.RESET_PC(32'h0000_0003), .ACK_TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_addr_o32(imem_addr_o32),
        .imem_ack_i(imem_ack_i), .imem_rdata_i32(imem_rdata_i32),
        .stall_i(stall_i), .branch_i(branch_i), .branch_off_i16(branch_off_i16),
        .pc_j_i(pc_j_i), .jaddr_i26(jaddr_i26),
        .instr_valid_o(instr_valid_o), .instr_o32(instr_o32), .op_o6(op_o6),
        .pc_o32(pc_o32), .pc_plus4_o32(pc_plus4_o32),
        .bus_err_o(bus_err_o), .align_err_o(align_err_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic        m_bus_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag);
        check({tag, ".valid"}, instr_valid_o, 0);
        check({tag, ".req"}, imem_req_o, 1);
        check({tag, ".addr"}, imem_addr_o32, m_pc);
        check({tag, ".bus_err"}, bus_err_o, m_bus_err);
        check({tag, ".align_err"}, align_err_o, 0);
    endtask

    task automatic check_have(input string tag);
        check({tag, ".valid"}, instr_valid_o, 1);
        check({tag, ".req"}, imem_req_o, 0);
        check({tag, ".instr"}, instr_o32, m_instr);
        check({tag, ".op"}, op_o6, m_instr >> 26);
        check({tag, ".pc"}, pc_o32, m_pc);
        check({tag, ".pc4"}, pc_plus4_o32, m_pc + 32'd4);
        check({tag, ".bus_err"}, bus_err_o, m_bus_err);
        check({tag, ".align_err"}, align_err_o, 0);
    endtask

    // Withhold ack for 'delay' cycles, then return word w.
    task automatic fetch(input logic [31:0] w, input int delay);
        check_fetch("fetch_start");
        for (int k = 1; k <= delay; k++) begin
            imem_ack_i = 1'b0;
            imem_rdata_i32 = $urandom;
            tick();
            if (k >= TMO) m_bus_err = 1'b1;
            check_fetch("fetch_wait");
        end
        imem_ack_i = 1'b1;
        imem_rdata_i32 = w;
        tick();
        imem_ack_i = 1'b0;
        imem_rdata_i32 = $urandom;
        m_instr = w;
        check_have("fetch_done");
    endtask

    // Hold stall for nstall cycles with noise on the ignored inputs, then consume.
    task automatic consume(input int nstall, input logic b, input logic [15:0] off,
                           input logic j, input logic [25:0] ja);
        logic [31:0] p4;
        for (int k = 0; k < nstall; k++) begin
            stall_i = 1'b1;
            branch_i = 1'($urandom);
            pc_j_i = 1'($urandom);
            branch_off_i16 = 16'($urandom);
            jaddr_i26 = 26'($urandom);
            imem_ack_i = 1'($urandom);
            imem_rdata_i32 = $urandom;
            tick();
            check_have("stalled");
        end
        imem_ack_i = 1'b0;
        stall_i = 1'b0;
        branch_i = b;
        branch_off_i16 = off;
        pc_j_i = j;
        jaddr_i26 = ja;
        p4 = m_pc + 32'd4;
        if (j)
            m_pc = (p4 & 32'hF000_0000) | ({6'b0, ja} * 32'd4);
        else if (b)
            m_pc = p4 + 32'($signed(off)) * 32'd4;
        else
            m_pc = p4;
        tick();
        stall_i = 1'b1;
        branch_i = 1'b0;
        pc_j_i = 1'b0;
        check_fetch("consumed");
    endtask

    initial begin
        // Reset: RESET_PC=3 must come out masked to 0.
        tick();
        tick();
        check("rst.valid", instr_valid_o, 0);
        check("rst.instr", instr_o32, 0);
        check("rst.pc", pc_o32, 0);
        check("rst.req", imem_req_o, 1);
        check("rst.bus_err", bus_err_o, 0);
        check("rst.align_err", align_err_o, 0);
        rst_i = 1'b0;

        // First fetch acked immediately; sequential consume.
        fetch(32'h8C08_0004, 0);
        check("first.op", op_o6, 6'h23);
        check("first.pc4", pc_plus4_o32, 32'd4);
        consume(0, 1'b0, 16'h0, 1'b0, 26'h0);
        check("first.next_addr", imem_addr_o32, 32'h4);

        // Branch backwards to the top of the address space, then wrap.
        fetch(32'h1000_FFFD, 1);
        consume(0, 1'b1, 16'hFFFD, 1'b0, 26'h0);
        check("to_top.addr", imem_addr_o32, 32'hFFFF_FFFC);
        fetch(32'h0000_0000, 0);
        consume(2, 1'b0, 16'h0, 1'b0, 26'h0);
        check("wrap.addr", imem_addr_o32, 32'h0);

        // Jump to 0x40, long stall, release with branch -2.
        fetch(32'h0800_0010, 0);
        consume(0, 1'b0, 16'h0, 1'b1, 26'h10);
        check("jmp40.addr", imem_addr_o32, 32'h40);
        fetch(32'h1000_FFFE, 2);
        consume(5, 1'b1, 16'hFFFE, 1'b0, 26'h0);
        check("br3c.addr", imem_addr_o32, 32'h3C);

        // Walk into region 1 and test jump priority over branch.
        fetch(32'h0BFF_FFFF, 0);
        consume(0, 1'b0, 16'h0, 1'b1, 26'h3FF_FFFF);
        check("jmp_ffc.addr", imem_addr_o32, 32'h0FFF_FFFC);
        fetch(32'h0000_0020, 0);
        consume(0, 1'b0, 16'h0, 1'b0, 26'h0);
        fetch(32'h0800_0004, 0);
        consume(0, 1'b0, 16'h0, 1'b1, 26'h4);
        check("jmp_reg1.addr", imem_addr_o32, 32'h1000_0010);
        fetch(32'h0800_0100, 1);
        consume(1, 1'b1, 16'h7FFF, 1'b1, 26'h100);
        check("jmp_prio.addr", imem_addr_o32, 32'h1000_0400);

        // Randomized stream; ack delays stay below the timeout.
        for (int i = 0; i < 40; i++) begin
            fetch($urandom, int'($urandom_range(0, TMO - 1)));
            consume(int'($urandom_range(0, 3)), 1'($urandom), 16'($urandom),
                    1'($urandom_range(0, 3) == 0), 26'($urandom));
        end

        // Ack timeout: error rises after the 4th unacked cycle, stays set, late ack loads.
        fetch(32'hDEAD_BEEF, 10);
        check("tmo.bus_err", bus_err_o, 1);
        consume(0, 1'b0, 16'h0, 1'b0, 26'h0);
        fetch(32'h1234_5678, 0);
        consume(0, 1'b0, 16'h0, 1'b0, 26'h0);

        // Reset coinciding with an ack abandons the fetch.
        rst_i = 1'b1;
        imem_ack_i = 1'b1;
        imem_rdata_i32 = 32'hCAFE_F00D;
        tick();
        rst_i = 1'b0;
        imem_ack_i = 1'b0;
        m_pc = 32'h0;
        m_bus_err = 1'b0;
        check("rst_ack.instr", instr_o32, 0);
        check("rst_ack.pc", pc_o32, 0);
        check_fetch("rst_ack");
        tick();
        check_fetch("rst_ack_next");
        fetch(32'h2000_0001, 0);
        consume(0, 1'b0, 16'h0, 1'b0, 26'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
